// File: rtl/dcmi_capture_pkg.sv
// Shared types for the DCMI capture front-end: FSM states, default geometry
// and the per-pixel marker flags.
package dcmi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } dcmi_state_e;

  localparam int DEF_H_ACTIVE = 400;
  localparam int DEF_V_ACTIVE = 300;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_flags_t;

endpackage

// File: rtl/dcmi_capture_if.sv
// Camera pins plus the outgoing pixel stream. The capture block uses the
// slave view; whatever drives the sensor pins and sinks the pixels uses master.
interface dcmi_capture_if #(
  parameter int DATA_W    = 8,
  parameter int PIX_BYTES = 2
);
  logic [DATA_W-1:0]           data;
  logic                        href;
  logic                        vsync;
  logic [DATA_W*PIX_BYTES-1:0] pix_data;
  logic                        pix_valid;
  logic                        pix_ready;
  logic                        pix_sof;
  logic                        pix_eol;
  logic                        pix_eof;

  modport slave (
    input  data, href, vsync, pix_ready,
    output pix_data, pix_valid, pix_sof, pix_eol, pix_eof
  );

  modport master (
    output data, href, vsync, pix_ready,
    input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof
  );
endinterface

// File: rtl/dcmi_capture_byte_pack.sv
// Byte-to-pixel packer: places each sensor byte into its lane and emits a
// registered one-cycle strobe together with the completed word.
module dcmi_byte_pack #(
  parameter int DATA_W    = 8,
  parameter int PIX_BYTES = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        take_i,
  output logic [DATA_W*PIX_BYTES-1:0] word_o,
  output logic                        pix_strobe_o,
  output logic                        partial_o
);
  localparam logic [1:0] LAST = 2'(PIX_BYTES - 1);

  logic [1:0]                  idx_q, idx_d, lane;
  logic [DATA_W*PIX_BYTES-1:0] word_q, word_d;
  logic                        strobe_q, strobe_d;

  // Index drops back to zero whenever bytes are not being taken, so every
  // new href high period starts on lane position 0.
  always_comb begin
    idx_d    = idx_q;
    word_d   = word_q;
    strobe_d = 1'b0;
    lane     = (MSB_FIRST != 0) ? (LAST - idx_q) : idx_q;
    if (take_i) begin
      word_d[int'(lane)*DATA_W +: DATA_W] = data_i;
      if (idx_q == LAST) begin
        idx_d    = '0;
        strobe_d = 1'b1;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end else begin
      idx_d = '0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      word_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      word_q   <= word_d;
      strobe_q <= strobe_d;
    end
  end

  assign word_o       = word_q;
  assign pix_strobe_o = strobe_q;
  assign partial_o    = (idx_q != 2'd0);
endmodule

// File: rtl/dcmi_capture.sv
// DCMI capture top: frame FSM, x/y counters, one-entry output register and
// error reporting. Define DCMI_CAPTURE_ERR_EN to build the saturating err_cnt.
//   state  | meaning
//   IDLE   | after reset, waiting for the first vsync
//   BLANK  | vsync high, counters cleared
//   ACTIVE | capturing lines
//   DONE   | all lines seen, href ignored until vsync
module dcmi_capture
  import dcmi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PIX_BYTES = 2,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int MSB_FIRST = 0
) (
  input  logic          pclk,
  input  logic          rst_n,
  dcmi_capture_if.slave bus,
  output logic          frame_done_o,
  output logic          overflow_o,
  output logic          line_err_o,
  output logic [15:0]   err_cnt_o
);
  localparam int PW = DATA_W * PIX_BYTES;
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  dcmi_state_e state_q, state_d;

  logic          href_q;
  logic [XW-1:0] x_q, x_d, x_cnt;
  logic [YW-1:0] y_q, y_d;
  logic          over_q, over_d, over_now;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_data_q, out_data_d;
  pix_flags_t    out_flags_q, out_flags_d, flags_now;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;
  logic          line_err_q, line_err_d;

  logic          take, strobe, partial;
  logic [PW-1:0] word;
  logic          pix_in, href_fall, x_full, cand, accept, load, drop;

  assign take = bus.href && (state_q == ACTIVE) && !bus.vsync;

  dcmi_byte_pack #(
    .DATA_W   (DATA_W),
    .PIX_BYTES(PIX_BYTES),
    .MSB_FIRST(MSB_FIRST)
  ) u_pack (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .data_i      (bus.data),
    .take_i      (take),
    .word_o      (word),
    .pix_strobe_o(strobe),
    .partial_o   (partial)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      BLANK:   if (!bus.vsync) state_d = ACTIVE;
      ACTIVE:  if (href_fall && (y_q == Y_LAST)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (bus.vsync) state_d = BLANK;
  end

  // The packer strobe lags the last byte by one cycle, so on the final pixel
  // of a line the strobe and the href fall coincide; x_cnt/over_now fold the
  // in-flight pixel into the line-length check.
  always_comb begin
    pix_in    = strobe && (state_q == ACTIVE) && !bus.vsync;
    href_fall = (state_q == ACTIVE) && href_q && !bus.href && !bus.vsync;
    x_full    = (x_q == X_END);
    x_cnt     = (pix_in && !x_full) ? x_q + XW'(1) : x_q;
    over_now  = over_q | (pix_in & x_full);
    cand      = pix_in && !x_full;
    accept    = out_valid_q && bus.pix_ready;
    load      = cand && (!out_valid_q || bus.pix_ready);
    drop      = cand && out_valid_q && !bus.pix_ready;

    flags_now.sof = (x_q == '0) && (y_q == '0);
    flags_now.eol = (x_q == X_LAST);
    flags_now.eof = (x_q == X_LAST) && (y_q == Y_LAST);

    x_d    = x_cnt;
    over_d = over_now;
    y_d    = y_q;
    if (href_fall) begin
      x_d    = '0;
      over_d = 1'b0;
      y_d    = y_q + YW'(1);
    end
    if ((state_q != ACTIVE) || bus.vsync) begin
      x_d    = '0;
      over_d = 1'b0;
      y_d    = '0;
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    if (accept) out_valid_d = 1'b0;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
      out_flags_d = flags_now;
    end

    frame_done_d = accept && out_flags_q.eof;
    overflow_d   = bus.vsync ? 1'b0 : (overflow_q | drop);
    line_err_d   = href_fall && ((x_cnt != X_END) || over_now || partial);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      over_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_flags_q  <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      href_q       <= bus.href;
      x_q          <= x_d;
      y_q          <= y_d;
      over_q       <= over_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_flags_q  <= out_flags_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      line_err_q   <= line_err_d;
    end
  end

`ifdef DCMI_CAPTURE_ERR_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;

  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + 17'(line_err_d) + 17'(drop);
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

  assign bus.pix_data  = out_data_q;
  assign bus.pix_valid = out_valid_q;
  assign bus.pix_sof   = out_flags_q.sof;
  assign bus.pix_eol   = out_flags_q.eol;
  assign bus.pix_eof   = out_flags_q.eof;
  assign frame_done_o  = frame_done_q;
  assign overflow_o    = overflow_q;
  assign line_err_o    = line_err_q;
endmodule

// File: tb/tb_dcmi_capture.sv
// Scoreboard bench for dcmi_capture on a 4x2 RGB565 frame, with a second
// instance built MSB_FIRST=1 sharing the same sensor pins.
module tb_dcmi_capture;
  localparam int DW = 8;
  localparam int PB = 2;
  localparam int H  = 4;
  localparam int V  = 2;
`ifdef DCMI_CAPTURE_ERR_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic        eof;
    logic [15:0] word;
  } exp_t;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_done_a, overflow_a, line_err_a;
  logic        frame_done_b, overflow_b, line_err_b;
  logic [15:0] err_cnt_a, err_cnt_b;
  logic [7:0]  nb = 8'd1;

  int   checks = 0;
  int   errors = 0;
  int   le_count = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [15:0] a_log[$];
  logic [15:0] b_log[$];

  dcmi_capture_if #(.DATA_W(DW), .PIX_BYTES(PB)) bus_a ();
  dcmi_capture_if #(.DATA_W(DW), .PIX_BYTES(PB)) bus_b ();

  dcmi_capture #(.DATA_W(DW), .PIX_BYTES(PB), .H_ACTIVE(H), .V_ACTIVE(V), .MSB_FIRST(0)) dut_a (
    .pclk(pclk), .rst_n(rst_n), .bus(bus_a),
    .frame_done_o(frame_done_a), .overflow_o(overflow_a),
    .line_err_o(line_err_a), .err_cnt_o(err_cnt_a)
  );

  dcmi_capture #(.DATA_W(DW), .PIX_BYTES(PB), .H_ACTIVE(H), .V_ACTIVE(V), .MSB_FIRST(1)) dut_b (
    .pclk(pclk), .rst_n(rst_n), .bus(bus_b),
    .frame_done_o(frame_done_b), .overflow_o(overflow_b),
    .line_err_o(line_err_b), .err_cnt_o(err_cnt_b)
  );

  assign bus_b.data      = bus_a.data;
  assign bus_b.href      = bus_a.href;
  assign bus_b.vsync     = bus_a.vsync;
  assign bus_b.pix_ready = 1'b1;

  always #5 pclk = ~pclk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] log_at(int which, int idx);
    if (which == 0) return (a_log.size() > idx) ? a_log[idx] : 16'hxxxx;
    return (b_log.size() > idx) ? b_log[idx] : 16'hxxxx;
  endfunction

  initial begin : mon_a
    exp_t e;
    bit   fd_pend;
    fd_pend = 1'b0;
    forever begin
      @(negedge pclk);
      if (!rst_n) begin
        fd_pend = 1'b0;
      end else begin
        if (fd_pend) begin
          check("frame_done", {31'd0, frame_done_a}, 32'd1);
          fd_pend = 1'b0;
        end else if (frame_done_a) begin
          check("frame_done_spurious", {31'd0, frame_done_a}, 32'd0);
        end
        if (bus_a.pix_valid && bus_a.pix_ready) begin
          if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel_a: got %h expected none", bus_a.pix_data);
          end else begin
            e = qa.pop_front();
            check("pixel_a", {13'd0, bus_a.pix_sof, bus_a.pix_eol, bus_a.pix_eof, bus_a.pix_data},
                  {13'd0, e});
            a_log.push_back(bus_a.pix_data);
            if (e.eof) fd_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge pclk);
      if (rst_n && bus_b.pix_valid && bus_b.pix_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel_b: got %h expected none", bus_b.pix_data);
        end else begin
          e = qb.pop_front();
          check("pixel_b", {13'd0, bus_b.pix_sof, bus_b.pix_eol, bus_b.pix_eof, bus_b.pix_data},
                {13'd0, e});
          b_log.push_back(bus_b.pix_data);
        end
      end
    end
  end

  initial begin : mon_le
    forever begin
      @(negedge pclk);
      if (line_err_a) le_count++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic vsync_pulse();
    tick();
    bus_a.vsync = 1'b1;
    bus_a.href  = 1'b0;
    repeat (3) tick();
    bus_a.vsync = 1'b0;
    nb = 8'd1;
    repeat (2) tick();
  endtask

  // cap: capture expected (ACTIVE); hold_a: instance A has pix_ready low for
  // the line, so only its first pixel is kept; abort: vsync hits mid-line.
  task automatic send_line(int nbytes, int yl, bit cap, bit hold_a, bit abort);
    int         x;
    bit         held;
    logic [7:0] b0;
    exp_t       e;
    x    = 0;
    held = 1'b0;
    b0   = 8'd0;
    for (int i = 0; i < nbytes; i++) begin
      tick();
      bus_a.href = 1'b1;
      bus_a.data = nb;
      if (i % 2 == 0) begin
        b0 = nb;
      end else begin
        if (cap && x < H) begin
          e.sof  = (x == 0) && (yl == 0);
          e.eol  = (x == H - 1);
          e.eof  = (x == H - 1) && (yl == V - 1);
          e.word = {nb, b0};
          if (!held) qa.push_back(e);
          if (hold_a) held = 1'b1;
          e.word = {b0, nb};
          qb.push_back(e);
        end
        x++;
      end
      nb = nb + 8'd1;
    end
    if (abort) begin
      tick();
      bus_a.vsync = 1'b1;
      bus_a.data  = nb;
      nb = nb + 8'd1;
    end
    tick();
    bus_a.href = 1'b0;
    if (abort) begin
      repeat (2) tick();
      bus_a.vsync = 1'b0;
      nb = 8'd1;
    end
    repeat (4) tick();
  endtask

  initial begin : stim
    bus_a.data      = 8'd0;
    bus_a.href      = 1'b0;
    bus_a.vsync     = 1'b0;
    bus_a.pix_ready = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_valid", {31'd0, bus_a.pix_valid}, 32'd0);
    check("rst_data", {16'd0, bus_a.pix_data}, 32'd0);
    check("rst_flags", {29'd0, bus_a.pix_sof, bus_a.pix_eol, bus_a.pix_eof}, 32'd0);
    check("rst_status_a", {13'd0, frame_done_a, overflow_a, line_err_a, err_cnt_a}, 32'd0);
    check("rst_status_b", {13'd0, frame_done_b, overflow_b, line_err_b, err_cnt_b}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    send_line(8, 0, 1'b0, 1'b0, 1'b0);
    vsync_pulse();
    send_line(8, 0, 1'b1, 1'b0, 1'b0);
    send_line(8, 1, 1'b1, 1'b0, 1'b0);
    send_line(8, 0, 1'b0, 1'b0, 1'b0);
    check("first_pix_a", {16'd0, log_at(0, 0)}, 32'h0201);
    check("eol_pix_a", {16'd0, log_at(0, 3)}, 32'h0807);
    check("eof_pix_a", {16'd0, log_at(0, 7)}, 32'h100F);
    check("first_pix_b", {16'd0, log_at(1, 0)}, 32'h0102);

    vsync_pulse();
    bus_a.pix_ready = 1'b0;
    send_line(8, 0, 1'b1, 1'b1, 1'b0);
    check("held_valid", {31'd0, bus_a.pix_valid}, 32'd1);
    check("held_word", {15'd0, bus_a.pix_sof, bus_a.pix_data}, 32'h1_0201);
    check("overflow_set", {31'd0, overflow_a}, 32'd1);
    check("err_cnt_drops", {16'd0, err_cnt_a}, (ERR_ON != 0) ? 32'd3 : 32'd0);
    repeat (3) tick();
    check("held_stable", {16'd0, bus_a.pix_data}, 32'h0201);
    bus_a.pix_ready = 1'b1;
    send_line(8, 1, 1'b1, 1'b0, 1'b0);
    check("overflow_sticky", {31'd0, overflow_a}, 32'd1);
    vsync_pulse();
    check("overflow_clr", {31'd0, overflow_a}, 32'd0);

    send_line(7, 0, 1'b1, 1'b0, 1'b0);
    send_line(8, 1, 1'b1, 1'b0, 1'b0);
    check("line_err_count", le_count, 32'd1);
    check("err_cnt_line", {16'd0, err_cnt_a}, (ERR_ON != 0) ? 32'd4 : 32'd0);

    vsync_pulse();
    send_line(8, 0, 1'b1, 1'b0, 1'b0);
    send_line(5, 1, 1'b1, 1'b0, 1'b1);
    send_line(8, 0, 1'b1, 1'b0, 1'b0);
    check("abort_no_line_err", le_count, 32'd1);
    bus_a.pix_ready = 1'b0;
    send_line(8, 1, 1'b1, 1'b1, 1'b0);
    check("pre_reset_valid", {30'd0, bus_a.pix_valid, overflow_a}, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_pix", {12'd0, bus_a.pix_valid, bus_a.pix_sof, bus_a.pix_eol, bus_a.pix_eof,
                            bus_a.pix_data}, 32'd0);
    check("async_rst_status", {13'd0, frame_done_a, overflow_a, line_err_a, err_cnt_a}, 32'd0);
    qa.delete();
    qb.delete();
    tick();
    rst_n = 1'b1;
    bus_a.pix_ready = 1'b1;
    send_line(8, 0, 1'b0, 1'b0, 1'b0);
    vsync_pulse();
    send_line(8, 0, 1'b1, 1'b0, 1'b0);
    send_line(8, 1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    check("qa_drained", qa.size(), 32'd0);
    check("qb_drained", qb.size(), 32'd0);
    check("line_err_final", le_count, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
